// File: rtl/resizer_stream_arbiter.sv
// Packet-level round-robin arbiter: shares one stream sink between N_REQ requesters.
// A grant is held from the first beat until the granted requester's last beat handshakes.
module resizer_stream_arbiter #(
    parameter int unsigned N_REQ        = 3,
    parameter int unsigned T_DATA_WIDTH = 1,
    parameter int unsigned M_KEEP_WIDTH = 2,
    parameter int unsigned IDX_W        = $clog2(N_REQ)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [N_REQ-1:0]                         s_valid_i,
    output logic [N_REQ-1:0]                         s_ready_o,
    input  logic [N_REQ-1:0]                         s_last_i,
    input  logic [N_REQ*M_KEEP_WIDTH-1:0]            s_keep_i,
    input  logic [N_REQ*M_KEEP_WIDTH*T_DATA_WIDTH-1:0] s_data_i,
    output logic                                     m_valid_o,
    input  logic                                     m_ready_i,
    output logic                                     m_last_o,
    output logic [M_KEEP_WIDTH-1:0]                  m_keep_o,
    output logic [M_KEEP_WIDTH*T_DATA_WIDTH-1:0]     m_data_o,
    output logic [IDX_W-1:0]                         grant_o,
    output logic                                     busy_o
);

    localparam int unsigned BEAT_W = M_KEEP_WIDTH * T_DATA_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_last_grant;
    logic [IDX_W-1:0] w_grant_nxt;
    logic [IDX_W-1:0] w_last_grant_nxt;
    logic [IDX_W-1:0] w_cand;
    logic [IDX_W-1:0] w_sel;
    logic             w_sel_vld;

    assign grant_o = r_grant;

    // State, grant and round-robin pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= IDX_W'(N_REQ - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Round-robin scan, next-state logic and zero-latency passthrough of the granted channel
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        s_ready_o        = '0;
        m_valid_o        = 1'b0;
        m_last_o         = 1'b0;
        m_keep_o         = '0;
        m_data_o         = '0;
        busy_o           = 1'b0;
        w_sel            = r_last_grant;
        w_sel_vld        = 1'b0;
        w_cand           = r_last_grant;

        // Scan last_grant+1 .. last_grant+N_REQ, wrapping so no index >= N_REQ is produced
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_cand = (w_cand == IDX_W'(N_REQ - 1)) ? '0 : w_cand + IDX_W'(1);
            if (!w_sel_vld && s_valid_i[w_cand]) begin
                w_sel     = w_cand;
                w_sel_vld = 1'b1;
            end
        end

        case (r_state)
            IDLE: begin
                if (w_sel_vld) begin
                    w_grant_nxt = w_sel;
                    w_state_nxt = LOCK;
                end
            end
            LOCK: begin
                busy_o = 1'b1;
                for (int unsigned r = 0; r < N_REQ; r++) begin
                    if (IDX_W'(r) == r_grant) begin
                        m_valid_o    = s_valid_i[r];
                        m_last_o     = s_last_i[r];
                        m_keep_o     = s_keep_i[r*M_KEEP_WIDTH +: M_KEEP_WIDTH];
                        m_data_o     = s_data_i[r*BEAT_W +: BEAT_W];
                        s_ready_o[r] = m_ready_i;
                    end
                end
                if (m_valid_o && m_ready_i && m_last_o) begin
                    w_last_grant_nxt = r_grant;
                    w_state_nxt      = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_resizer_stream_arbiter.sv
// Directed, table-driven bench for resizer_stream_arbiter (N_REQ=3, 2 lanes of 1 bit).
module tb_resizer_stream_arbiter;

    logic       clk;
    logic       rst_n;
    logic [2:0] s_valid_i;
    logic [2:0] s_ready_o;
    logic [2:0] s_last_i;
    logic [5:0] s_keep_i;
    logic [5:0] s_data_i;
    logic       m_valid_o;
    logic       m_ready_i;
    logic       m_last_o;
    logic [1:0] m_keep_o;
    logic [1:0] m_data_o;
    logic [1:0] grant_o;
    logic       busy_o;

    int n_checks;
    int n_err;

    resizer_stream_arbiter #(
        .N_REQ(3), .T_DATA_WIDTH(1), .M_KEEP_WIDTH(2), .IDX_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_last_i(s_last_i),
        .s_keep_i(s_keep_i), .s_data_i(s_data_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_o(m_last_o),
        .m_keep_o(m_keep_o), .m_data_o(m_data_o),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] v;
        logic [2:0] l;
        logic [5:0] k;
        logic [5:0] d;
        logic       mr;
        logic       ev;
        logic       el;
        logic [1:0] ek;
        logic [1:0] ed;
        logic [2:0] esr;
        logic [1:0] eg;
        logic       eb;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [2:0] v, input logic [2:0] l,
                                input logic [5:0] k, input logic [5:0] d, input logic mr,
                                input logic ev, input logic el, input logic [1:0] ek,
                                input logic [1:0] ed, input logic [2:0] esr,
                                input logic [1:0] eg, input logic eb);
        vec_t t;
        t.rst = rst; t.v = v; t.l = l; t.k = k; t.d = d; t.mr = mr;
        t.ev = ev; t.el = el; t.ek = ek; t.ed = ed; t.esr = esr; t.eg = eg; t.eb = eb;
        return t;
    endfunction

    // IDLE cycle: every output zero except the held grant index
    function automatic vec_t idl(input logic rst, input logic [2:0] v, input logic [2:0] l,
                                 input logic mr, input logic [1:0] eg);
        return mk(rst, v, l, 6'b0, 6'b0, mr, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, eg, 1'b0);
    endfunction

    function automatic logic [11:0] act_bundle();
        return {m_valid_o, m_last_o, m_keep_o, m_data_o, s_ready_o, grant_o, busy_o};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {vld,last,keep,data,s_rdy,grant,busy}=%b required %b",
                     name, act, exp);
        end
    endtask

    task automatic drive_zero();
        s_valid_i = '0; s_last_i = '0; s_keep_i = '0; s_data_i = '0; m_ready_i = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 with reset released
    task automatic do_reset();
        drive_zero();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        drive_zero();
        rst_n = 1'b0;
        #1;
        check("reset", act_bundle(), 12'b0);

        // Single requester 1, 3-beat packet
        tbl.push_back(idl(1'b1, 3'b010, 3'b000, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 3'b010, 3'b000, {2'b10,2'b11,2'b01}, {2'b01,2'b10,2'b10}, 1'b1,
                         1'b1, 1'b0, 2'b11, 2'b10, 3'b010, 2'd1, 1'b1));
        tbl.push_back(mk(1'b0, 3'b010, 3'b000, {2'b10,2'b11,2'b01}, {2'b01,2'b01,2'b10}, 1'b1,
                         1'b1, 1'b0, 2'b11, 2'b01, 3'b010, 2'd1, 1'b1));
        tbl.push_back(mk(1'b0, 3'b010, 3'b010, {2'b10,2'b01,2'b01}, {2'b01,2'b11,2'b10}, 1'b1,
                         1'b1, 1'b1, 2'b01, 2'b11, 3'b010, 2'd1, 1'b1));
        tbl.push_back(idl(1'b0, 3'b000, 3'b000, 1'b1, 2'd1));

        // All three requesters continuously valid with 1-beat packets: 0,1,2,0,1,2
        tbl.push_back(idl(1'b1, 3'b111, 3'b111, 1'b1, 2'd0));
        for (int rep = 0; rep < 2; rep++) begin
            tbl.push_back(mk(1'b0, 3'b111, 3'b111, 6'b111111, 6'b111001, 1'b1,
                             1'b1, 1'b1, 2'b11, 2'b01, 3'b001, 2'd0, 1'b1));
            tbl.push_back(idl(1'b0, 3'b111, 3'b111, 1'b1, 2'd0));
            tbl.push_back(mk(1'b0, 3'b111, 3'b111, 6'b111111, 6'b111001, 1'b1,
                             1'b1, 1'b1, 2'b11, 2'b10, 3'b010, 2'd1, 1'b1));
            tbl.push_back(idl(1'b0, 3'b111, 3'b111, 1'b1, 2'd1));
            tbl.push_back(mk(1'b0, 3'b111, 3'b111, 6'b111111, 6'b111001, 1'b1,
                             1'b1, 1'b1, 2'b11, 2'b11, 3'b100, 2'd2, 1'b1));
            tbl.push_back(idl(1'b0, 3'b111, 3'b111, 1'b1, 2'd2));
        end

        // Backpressure on requester 0 for 4 cycles, then accepted
        tbl.push_back(idl(1'b1, 3'b001, 3'b001, 1'b0, 2'd0));
        for (int c = 0; c < 4; c++)
            tbl.push_back(mk(1'b0, 3'b001, 3'b001, 6'b000010, 6'b000011, 1'b0,
                             1'b1, 1'b1, 2'b10, 2'b11, 3'b000, 2'd0, 1'b1));
        tbl.push_back(mk(1'b0, 3'b001, 3'b001, 6'b000010, 6'b000011, 1'b1,
                         1'b1, 1'b1, 2'b10, 2'b11, 3'b001, 2'd0, 1'b1));
        tbl.push_back(idl(1'b0, 3'b000, 3'b000, 1'b1, 2'd0));

        // Requester 2 bubbles for 2 cycles while requester 0 waits
        tbl.push_back(idl(1'b1, 3'b100, 3'b000, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 3'b100, 3'b000, {2'b11,2'b00,2'b01}, {2'b10,2'b00,2'b11}, 1'b1,
                         1'b1, 1'b0, 2'b11, 2'b10, 3'b100, 2'd2, 1'b1));
        for (int c = 0; c < 2; c++)
            tbl.push_back(mk(1'b0, 3'b001, 3'b000, {2'b11,2'b00,2'b01}, {2'b10,2'b00,2'b11}, 1'b1,
                             1'b0, 1'b0, 2'b11, 2'b10, 3'b100, 2'd2, 1'b1));
        tbl.push_back(mk(1'b0, 3'b101, 3'b100, {2'b01,2'b00,2'b01}, {2'b01,2'b00,2'b11}, 1'b1,
                         1'b1, 1'b1, 2'b01, 2'b01, 3'b100, 2'd2, 1'b1));
        tbl.push_back(idl(1'b0, 3'b001, 3'b001, 1'b1, 2'd2));
        tbl.push_back(mk(1'b0, 3'b001, 3'b001, {2'b01,2'b00,2'b01}, {2'b01,2'b00,2'b11}, 1'b1,
                         1'b1, 1'b1, 2'b01, 2'b11, 3'b001, 2'd0, 1'b1));
        tbl.push_back(idl(1'b0, 3'b000, 3'b000, 1'b1, 2'd0));

        // Last beat of requester 0 coincides with new requests from 0 and 1; keep=0 beat passes
        tbl.push_back(idl(1'b1, 3'b001, 3'b000, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 3'b001, 3'b000, {2'b00,2'b11,2'b10}, {2'b00,2'b01,2'b11}, 1'b1,
                         1'b1, 1'b0, 2'b10, 2'b11, 3'b001, 2'd0, 1'b1));
        tbl.push_back(mk(1'b0, 3'b011, 3'b001, {2'b00,2'b11,2'b10}, {2'b00,2'b01,2'b11}, 1'b1,
                         1'b1, 1'b1, 2'b10, 2'b11, 3'b001, 2'd0, 1'b1));
        tbl.push_back(idl(1'b0, 3'b011, 3'b011, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 3'b011, 3'b011, {2'b00,2'b00,2'b10}, {2'b00,2'b11,2'b11}, 1'b1,
                         1'b1, 1'b1, 2'b00, 2'b11, 3'b010, 2'd1, 1'b1));
        tbl.push_back(idl(1'b0, 3'b001, 3'b001, 1'b1, 2'd1));
        tbl.push_back(mk(1'b0, 3'b001, 3'b001, {2'b00,2'b00,2'b10}, {2'b00,2'b11,2'b11}, 1'b1,
                         1'b1, 1'b1, 2'b10, 2'b11, 3'b001, 2'd0, 1'b1));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            s_valid_i = tbl[i].v;
            s_last_i  = tbl[i].l;
            s_keep_i  = tbl[i].k;
            s_data_i  = tbl[i].d;
            m_ready_i = tbl[i].mr;
            #4;
            check($sformatf("vec%0d", i), act_bundle(),
                  {tbl[i].ev, tbl[i].el, tbl[i].ek, tbl[i].ed, tbl[i].esr, tbl[i].eg, tbl[i].eb});
            @(posedge clk);
            #1;
        end

        // Asynchronous reset during beat 2 of a 4-beat packet from requester 1
        do_reset();
        s_valid_i = 3'b010; s_last_i = 3'b000; m_ready_i = 1'b1;
        s_keep_i = {2'b00,2'b11,2'b00}; s_data_i = {2'b00,2'b10,2'b00};
        #4;
        check("rstseq_idle", act_bundle(), {1'b0,1'b0,2'b00,2'b00,3'b000,2'd0,1'b0});
        @(posedge clk);
        #1;
        #4;
        check("rstseq_beat1", act_bundle(), {1'b1,1'b0,2'b11,2'b10,3'b010,2'd1,1'b1});
        @(posedge clk);
        #1;
        #2;
        drive_zero();
        rst_n = 1'b0;
        #1;
        check("rstseq_async", act_bundle(), 12'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        s_valid_i = 3'b011; s_last_i = 3'b011; m_ready_i = 1'b1;
        s_keep_i = {2'b00,2'b11,2'b01}; s_data_i = {2'b00,2'b10,2'b01};
        #4;
        check("rstseq_post_idle", act_bundle(), {1'b0,1'b0,2'b00,2'b00,3'b000,2'd0,1'b0});
        @(posedge clk);
        #1;
        #4;
        check("rstseq_post_grant0", act_bundle(), {1'b1,1'b1,2'b01,2'b01,3'b001,2'd0,1'b1});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/resizer_stream_arbiter.md
Name: resizer_stream_arbiter

Overview:
- Packet-level round-robin arbiter that shares one resizer output stream interface between N_REQ upstream requesters.
- Each requester presents valid/ready/last/keep/data beats. The arbiter grants one requester and holds the grant until that requester's last beat handshakes, so packets never interleave.
- Sits between the requester channels and the downstream sink, on the same stream conventions as the resizer master port.

Parameters:
- N_REQ, 3, number of requester channels (>=2).
- T_DATA_WIDTH, 1, width of one data lane.
- M_KEEP_WIDTH, 2, number of lanes per beat (keep bits per beat).
- IDX_W, $clog2(N_REQ), width of the grant index.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid_i  in  N_REQ  per-requester beat valid.
- s_ready_o  out  N_REQ  per-requester beat ready.
- s_last_i  in  N_REQ  per-requester end-of-packet flag.
- s_keep_i  in  N_REQ*M_KEEP_WIDTH  requester r occupies bits [r*M_KEEP_WIDTH +: M_KEEP_WIDTH].
- s_data_i  in  N_REQ*M_KEEP_WIDTH*T_DATA_WIDTH  requester r occupies slice r of width M_KEEP_WIDTH*T_DATA_WIDTH; lane j of that slice at [j*T_DATA_WIDTH +: T_DATA_WIDTH].
- m_valid_o  out  1  downstream beat valid.
- m_ready_i  in  1  downstream ready.
- m_last_o  out  1  downstream end-of-packet.
- m_keep_o  out  M_KEEP_WIDTH  downstream keep.
- m_data_o  out  M_KEEP_WIDTH*T_DATA_WIDTH  downstream data, same lane packing.
- grant_o  out  IDX_W  index of the currently or most recently granted requester (registered).
- busy_o  out  1  1 while in LOCK.

Behaviour:
- FSM states: IDLE, LOCK. Registers: state, grant_o, last_grant (IDX_W).
- Reset (async, rst_n=0):
  - state=IDLE, grant_o=0, last_grant=N_REQ-1, so requester 0 has first priority.
  - All outputs are driven to 0 while in reset.
- IDLE:
  - m_valid_o=0, m_last_o=0, m_keep_o=0, m_data_o=0, s_ready_o=0, busy_o=0.
  - If any s_valid_i is set: select the first set bit scanning last_grant+1, last_grant+2, …, wrapping modulo N_REQ.
  - On the next posedge: grant_o<=selected, state<=LOCK.
  - Arbitration latency is exactly 1 cycle. No beat is accepted in IDLE.
- LOCK, with g=grant_o (combinational passthrough, zero latency):
  - m_valid_o=s_valid_i[g], m_last_o=s_last_i[g], m_keep_o=keep slice g, m_data_o=data slice g.
  - s_ready_o[g]=m_ready_i; all other s_ready_o bits are 0.
  - busy_o=1.
  - Handshake occurs when s_valid_i[g] & m_ready_i.
  - A handshake with s_last_i[g]=1: on that posedge last_grant<=g, state<=IDLE.
  - A handshake without last: stay in LOCK.
  - s_valid_i[g]=0 (bubble): stay in LOCK and keep the grant. No timeout; the packet must complete.
- Back-to-back packets: after a last beat there is always one IDLE cycle before the next grant. The arbiter never issues two grants in consecutive cycles.
- Requests from non-granted channels: ignored while in LOCK. They are evaluated in the IDLE cycle only.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0. No requester waits more than N_REQ-1 packets.
- Simultaneous events:
  - Last-beat handshake and new requests in the same cycle: the new requests are arbitrated in the following IDLE cycle, using the updated last_grant.
- Keep contents: never inspected or modified. Beats with keep=0 pass through unchanged.
- Reset mid-packet: immediate return to IDLE with all outputs 0. The partially sent packet is not terminated by this block.
- Index wrap: last_grant=N_REQ-1 wraps the scan to 0. Non-power-of-2 N_REQ must never select an index >= N_REQ.

Test Plan:
- Single requester 1 sends 3-beat packet (keep=2'b11, 2'b11, 2'b01 with last), m_ready_i=1 -> one IDLE cycle, then grant_o=1, 3 beats forwarded in 3 consecutive cycles, m_last_o=1 on beat 3, back to IDLE, busy_o low.
- N_REQ=3, all three requesters valid with 1-beat packets continuously after reset -> grant order 0,1,2,0,1,2, each grant separated by exactly one IDLE cycle.
- Backpressure: granted requester 0 valid, m_ready_i=0 for 4 cycles -> s_ready_o=3'b000, m_valid_o=1 with data stable; m_ready_i=1 -> beat accepted, s_ready_o[0]=1.
- Mid-packet bubble: requester 2 drops s_valid_i for 2 cycles while requester 0 is valid -> grant_o stays 2, m_valid_o=0 during the bubble, and requester 0 is not served until requester 2's last beat.
- Reset asserted during beat 2 of a 4-beat packet -> asynchronously, m_valid_o=0, s_ready_o=0, busy_o=0. After release with requesters 0 and 1 valid, requester 0 is granted first.
- Last-beat handshake coinciding with new s_valid_i from the requester just served and from the next requester -> the next requester (last_grant+1) wins; the just-served requester waits one packet.
